// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential load/store unit behind a byte-wide data memory port.
// Takes one decoded access (mem_read/mem_write codes) at a time and runs it as one byte
// beat per cycle, little-endian. The final load data is sign- or zero-extended. Misaligned
// and illegal requests get an error response and no memory beats.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/ready_o   request handshake; ready only while idle
//   mem_read_i[2:0]       000 none, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU, 11x reserved
//   mem_write_i[1:0]      00 none, 01 SW, 10 SH, 11 SB
//   addr_i, wdata_i       byte address, LSB-aligned store data
//   rsp_valid_o           one-cycle completion pulse
//   rsp_rdata_o           extended load data (0 for stores, errors and no-ops)
//   rsp_err_o             request rejected, qualified by rsp_valid_o
//   mb_*                  byte memory port; mb_rdata_i is valid the cycle after mb_re_o
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        mem_read_i,
  input  logic [1:0]        mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] mb_addr_o,
  output logic              mb_re_o,
  output logic              mb_we_o,
  output logic [7:0]        mb_wdata_o,
  input  logic [7:0]        mb_rdata_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StResp} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        last_q, last_d;       // index of the final beat: 3 word, 1 half, 0 byte
  logic              is_load_q, is_load_d;
  logic              sext_q, sext_d;
  logic [23:0]       wsh_q, wsh_d;         // store bytes not yet sent, next one in [7:0]
  logic [31:0]       asm_q, asm_d;         // load assembly bytes
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] mb_addr_q, mb_addr_d;
  logic              mb_re_q, mb_re_d;
  logic              mb_we_q, mb_we_d;
  logic [7:0]        mb_wdata_q, mb_wdata_d;

  // Request decode, only meaningful at accept.
  logic       is_rd, is_wr, dec_err;
  logic [1:0] dec_last;

  always_comb begin
    is_rd    = (mem_read_i != 3'b000);
    is_wr    = (mem_write_i != 2'b00);
    dec_last = 2'd0;
    if (is_rd) begin
      case (mem_read_i)
        3'b001:         dec_last = 2'd3;
        3'b010, 3'b011: dec_last = 2'd1;
        default:        dec_last = 2'd0;
      endcase
    end else begin
      case (mem_write_i)
        2'b01:   dec_last = 2'd3;
        2'b10:   dec_last = 2'd1;
        default: dec_last = 2'd0;
      endcase
    end
    dec_err = (is_rd && is_wr) || (mem_read_i[2:1] == 2'b11) ||
              (dec_last == 2'd3 && addr_i[1:0] != 2'b00) ||
              (dec_last == 2'd1 && addr_i[0]);
  end

  // The last load byte arrives during DRAIN and is merged straight into the result.
  logic [31:0] word_c, load_c;

  always_comb begin
    word_c = asm_q;
    word_c[{last_q, 3'b000} +: 8] = mb_rdata_i;
    case (last_q)
      2'd3:    load_c = word_c;
      2'd1:    load_c = {{16{sext_q & word_c[15]}}, word_c[15:0]};
      default: load_c = {{24{sext_q & word_c[7]}}, word_c[7:0]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_d      = last_q;
    is_load_d   = is_load_q;
    sext_d      = sext_q;
    wsh_d       = wsh_q;
    asm_d       = asm_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mb_addr_d   = mb_addr_q;
    mb_re_d     = 1'b0;
    mb_we_d     = 1'b0;
    mb_wdata_d  = mb_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_q) begin
          last_d    = dec_last;
          is_load_d = is_rd;
          sext_d    = (mem_read_i == 3'b010) || (mem_read_i == 3'b100);
          wsh_d     = wdata_i[31:8];
          if (dec_err || (!is_rd && !is_wr)) begin
            state_d     = StResp;
            rsp_err_d   = dec_err;
            rsp_rdata_d = '0;
          end else begin
            // Beat 0 goes out in the first cycle after accept.
            state_d   = StIssue;
            beat_d    = 2'd0;
            mb_addr_d = addr_i;
            mb_re_d   = is_rd;
            mb_we_d   = is_wr;
            if (is_wr) mb_wdata_d = wdata_i[7:0];
          end
        end
      end
      StIssue: begin
        // Byte for the previous read beat is on mb_rdata_i now.
        if (beat_q != 2'd0) asm_d[{beat_q - 2'd1, 3'b000} +: 8] = mb_rdata_i;
        if (beat_q == last_q) begin
          if (is_load_q) begin
            state_d = StDrain;
          end else begin
            state_d     = StResp;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end
        end else begin
          beat_d    = beat_q + 2'd1;
          mb_addr_d = mb_addr_q + AddrOne;
          mb_re_d   = is_load_q;
          mb_we_d   = !is_load_q;
          if (!is_load_q) begin
            mb_wdata_d = wsh_q[7:0];
            wsh_d      = wsh_q >> 8;
          end
        end
      end
      StDrain: begin
        state_d     = StResp;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = load_c;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      beat_q      <= 2'd0;
      last_q      <= 2'd0;
      is_load_q   <= 1'b0;
      sext_q      <= 1'b0;
      wsh_q       <= '0;
      asm_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mb_addr_q   <= '0;
      mb_re_q     <= 1'b0;
      mb_we_q     <= 1'b0;
      mb_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      is_load_q   <= is_load_d;
      sext_q      <= sext_d;
      wsh_q       <= wsh_d;
      asm_q       <= asm_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mb_addr_q   <= mb_addr_d;
      mb_re_q     <= mb_re_d;
      mb_we_q     <= mb_we_d;
      mb_wdata_q  <= mb_wdata_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mb_addr_o   = mb_addr_q;
  assign mb_re_o     = mb_re_q;
  assign mb_we_o     = mb_we_q;
  assign mb_wdata_o  = mb_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan scenarios plus randomized requests
// checked against a byte-array reference model of the unit's architectural behaviour.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] addr, wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mb_addr;
  logic        mb_re, mb_we;
  logic [7:0]  mb_wdata, mb_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .addr_i(addr), .wdata_i(wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mb_addr_o(mb_addr), .mb_re_o(mb_re), .mb_we_o(mb_we), .mb_wdata_o(mb_wdata),
    .mb_rdata_i(mb_rdata)
  );

  function automatic logic [7:0] init_byte(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5C;
  endfunction

  // Byte RAM seen by the DUT: one-cycle read latency, 4 KiB window.
  logic [7:0] ram_b [0:4095];
  bit         ram_v [0:4095];
  always @(posedge clk) begin
    if (mb_re) mb_rdata <= ram_v[mb_addr[11:0]] ? ram_b[mb_addr[11:0]] : init_byte(mb_addr[11:0]);
    if (mb_we) begin
      ram_b[mb_addr[11:0]] <= mb_wdata;
      ram_v[mb_addr[11:0]] <= 1'b1;
    end
  end

  // Reference model state.
  logic [7:0]  refm [0:4095];
  logic        exp_err, exp_load, exp_store;
  logic [31:0] exp_rdata;
  int          exp_n, exp_lat;

  task automatic model(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                       input logic [31:0] wd);
    logic [31:0] v;
    exp_err = 1'b0; exp_load = 1'b0; exp_store = 1'b0; exp_n = 0; exp_rdata = 32'd0;
    if (rd != 3'd0 && wr != 2'd0) exp_err = 1'b1;
    else if (rd >= 3'd6) exp_err = 1'b1;
    else if (rd != 3'd0) begin
      exp_load = 1'b1;
      exp_n = (rd == 3'd1) ? 4 : (rd <= 3'd3) ? 2 : 1;
    end else if (wr != 2'd0) begin
      exp_store = 1'b1;
      exp_n = (wr == 2'd1) ? 4 : (wr == 2'd2) ? 2 : 1;
    end
    if (exp_n != 0 && (a % exp_n) != 0) exp_err = 1'b1;
    if (exp_err) begin
      exp_n = 0; exp_load = 1'b0; exp_store = 1'b0; exp_lat = 1;
    end else if (exp_n == 0) begin
      exp_lat = 1;
    end else if (exp_load) begin
      v = 32'd0;
      for (int i = 0; i < exp_n; i++) v = v + (32'(refm[12'(a + 32'(i))]) << (8 * i));
      if (rd == 3'd2 && v >= 32'h8000) v = v - 32'h10000;
      if (rd == 3'd4 && v >= 32'h80) v = v - 32'h100;
      exp_rdata = v;
      exp_lat = exp_n + 2;
    end else begin
      for (int i = 0; i < exp_n; i++) refm[12'(a + 32'(i))] = 8'(wd >> (8 * i));
      exp_lat = exp_n + 1;
    end
  endtask

  // Per-cycle observations of one request; index k = cycle k after the accept edge.
  logic        obs_re [0:23];
  logic        obs_we [0:23];
  logic        obs_rdy [0:23];
  logic [31:0] obs_addr [0:23];
  logic [7:0]  obs_wd [0:23];
  int          obs_lat;
  logic        obs_err, obs_rdy_after;
  logic [31:0] obs_rdata;

  task automatic record(input int k);
    obs_re[k] = mb_re; obs_we[k] = mb_we; obs_rdy[k] = req_ready;
    obs_addr[k] = mb_addr; obs_wd[k] = mb_wdata;
  endtask

  // Issue one request from a negedge with the unit idle; optionally keep req_valid high
  // with different inputs while busy.
  task automatic run_req(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold);
    int idx;
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      mem_read = 3'b000; mem_write = 2'b01; addr = 32'h200; wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    obs_lat = 0; obs_err = 1'bx; obs_rdata = 'x;
    for (int k = 1; k <= 20 && obs_lat == 0; k++) begin
      @(negedge clk);
      record(k);
      if (rsp_valid) begin
        obs_lat = k; obs_err = rsp_err; obs_rdata = rsp_rdata;
      end
    end
    @(negedge clk);
    idx = (obs_lat == 0) ? 21 : obs_lat + 1;
    record(idx);
    obs_rdy_after = req_ready;
    req_valid = 1'b0; mem_read = 3'b000; mem_write = 2'b00;
  endtask

  // Number of cycles whose strobes/addresses/ready differ from what the model expects.
  function automatic int beat_mismatches(input logic [31:0] a, input logic [31:0] wd);
    int bad = 0;
    for (int k = 1; k <= exp_lat + 1; k++) begin
      bit on = (k <= exp_n);
      if (obs_re[k] !== (on && exp_load)) bad++;
      if (obs_we[k] !== (on && exp_store)) bad++;
      if (on && obs_addr[k] !== a + 32'(k - 1)) bad++;
      if (on && exp_store && obs_wd[k] !== 8'(wd >> (8 * (k - 1)))) bad++;
      if (k <= exp_lat && obs_rdy[k] !== 1'b0) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mb_re, mb_we} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 10000", {req_ready, rsp_valid, rsp_err, mb_re, mb_we});
    end
    checks++;
    if (rsp_rdata !== 32'd0 || mb_addr !== 32'd0 || mb_wdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want all 0", rsp_rdata, mb_addr, mb_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    logic [7:0] sw_b [0:3];
    int bad = 0;
    sw_b[0] = 8'hEF; sw_b[1] = 8'hBE; sw_b[2] = 8'hAD; sw_b[3] = 8'hDE;
    model(3'b000, 2'b01, 32'h100, 32'hDEADBEEF);
    run_req(3'b000, 2'b01, 32'h100, 32'hDEADBEEF, 1'b0);
    checks++;
    if (obs_lat !== 5 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL sw_resp: got cycle %0d err %b want cycle 5 err 0", obs_lat, obs_err);
    end
    for (int k = 1; k <= 4; k++)
      if (obs_we[k] !== 1'b1 || obs_re[k] !== 1'b0 || obs_addr[k] !== 32'h100 + 32'(k - 1) ||
          obs_wd[k] !== sw_b[k-1]) bad++;
    if (obs_we[5] !== 1'b0 || obs_re[5] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sw_beats: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (obs_rdy_after !== 1'b1) begin
      errors++;
      $display("FAIL sw_ready_after: got %b want 1", obs_rdy_after);
    end
    // Set up bytes 0x80,0xFF,0x12,0x34 at 0x100 for the load tests.
    model(3'b000, 2'b01, 32'h100, 32'h3412FF80);
    run_req(3'b000, 2'b01, 32'h100, 32'h3412FF80, 1'b0);
    checks++;
    if (beat_mismatches(32'h100, 32'h3412FF80) != 0 || obs_lat !== 5) begin
      errors++;
      $display("FAIL sw_preload: got cycle %0d want 5 with clean beats", obs_lat);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  rd_t [0:4];
    logic [31:0] a_t [0:4];
    logic [31:0] d_t [0:4];
    int          n_t [0:4];
    rd_t[0] = 3'b001; a_t[0] = 32'h100; d_t[0] = 32'h3412FF80; n_t[0] = 4;
    rd_t[1] = 3'b010; a_t[1] = 32'h100; d_t[1] = 32'hFFFFFF80; n_t[1] = 2;
    rd_t[2] = 3'b011; a_t[2] = 32'h100; d_t[2] = 32'h0000FF80; n_t[2] = 2;
    rd_t[3] = 3'b100; a_t[3] = 32'h100; d_t[3] = 32'hFFFFFF80; n_t[3] = 1;
    rd_t[4] = 3'b101; a_t[4] = 32'h101; d_t[4] = 32'h000000FF; n_t[4] = 1;
    for (int i = 0; i < 5; i++) begin
      model(rd_t[i], 2'b00, a_t[i], 32'd0);
      run_req(rd_t[i], 2'b00, a_t[i], 32'd0, 1'b0);
      checks++;
      if (obs_rdata !== d_t[i] || obs_err !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_data: got %h err %b want %h err 0", i, obs_rdata, obs_err, d_t[i]);
      end
      checks++;
      if (obs_lat !== n_t[i] + 2) begin
        errors++;
        $display("FAIL load%0d_cycle: got %0d want %0d", i, obs_lat, n_t[i] + 2);
      end
      checks++;
      if (beat_mismatches(a_t[i], 32'd0) != 0) begin
        errors++;
        $display("FAIL load%0d_beats: got %0d bad cycles want 0", i, beat_mismatches(a_t[i], 32'd0));
      end
    end
  endtask

  task automatic test_errors;
    logic [2:0]  rd_t [0:3];
    logic [1:0]  wr_t [0:3];
    logic [31:0] a_t [0:3];
    rd_t[0] = 3'b001; wr_t[0] = 2'b00; a_t[0] = 32'h102;
    rd_t[1] = 3'b000; wr_t[1] = 2'b10; a_t[1] = 32'h101;
    rd_t[2] = 3'b110; wr_t[2] = 2'b00; a_t[2] = 32'h100;
    rd_t[3] = 3'b001; wr_t[3] = 2'b01; a_t[3] = 32'h100;
    for (int i = 0; i < 4; i++) begin
      run_req(rd_t[i], wr_t[i], a_t[i], 32'hCAFEF00D, 1'b0);
      checks++;
      if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'd0) begin
        errors++;
        $display("FAIL err%0d_resp: got cycle %0d err %b data %h want cycle 1 err 1 data 0",
                 i, obs_lat, obs_err, obs_rdata);
      end
      checks++;
      if (obs_re[1] !== 1'b0 || obs_we[1] !== 1'b0 || obs_re[2] !== 1'b0 || obs_we[2] !== 1'b0) begin
        errors++;
        $display("FAIL err%0d_strobes: got re %b%b we %b%b want 0000", i, obs_re[1], obs_re[2],
                 obs_we[1], obs_we[2]);
      end
    end
  endtask

  task automatic test_sb_hold;
    model(3'b000, 2'b11, 32'h103, 32'hAABBCC5A);
    run_req(3'b000, 2'b11, 32'h103, 32'hAABBCC5A, 1'b1);
    checks++;
    if (obs_we[1] !== 1'b1 || obs_addr[1] !== 32'h103 || obs_wd[1] !== 8'h5A) begin
      errors++;
      $display("FAIL sb_write: got we %b addr %h data %h want 1 103 5a", obs_we[1], obs_addr[1], obs_wd[1]);
    end
    checks++;
    if (obs_lat !== 2 || obs_err !== 1'b0 || beat_mismatches(32'h103, 32'hAABBCC5A) != 0) begin
      errors++;
      $display("FAIL sb_busy: got cycle %0d err %b mismatches %0d want cycle 2 err 0 none",
               obs_lat, obs_err, beat_mismatches(32'h103, 32'hAABBCC5A));
    end
    checks++;
    if (obs_rdy_after !== 1'b1) begin
      errors++;
      $display("FAIL sb_ready_after: got %b want 1", obs_rdy_after);
    end
    model(3'b101, 2'b00, 32'h103, 32'd0);
    run_req(3'b101, 2'b00, 32'h103, 32'd0, 1'b0);
    checks++;
    if (obs_rdata !== 32'h0000005A) begin
      errors++;
      $display("FAIL sb_readback: got %h want 0000005a", obs_rdata);
    end
  endtask

  task automatic test_noop;
    model(3'b000, 2'b00, 32'h40, 32'h12345678);
    run_req(3'b000, 2'b00, 32'h40, 32'h12345678, 1'b0);
    checks++;
    if (obs_lat !== 1 || obs_err !== 1'b0 || obs_rdata !== 32'd0) begin
      errors++;
      $display("FAIL noop_resp: got cycle %0d err %b data %h want cycle 1 err 0 data 0",
               obs_lat, obs_err, obs_rdata);
    end
    checks++;
    if (beat_mismatches(32'h40, 32'h12345678) != 0) begin
      errors++;
      $display("FAIL noop_strobes: got %0d bad cycles want 0", beat_mismatches(32'h40, 32'h12345678));
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    mem_read = 3'b001; mem_write = 2'b00; addr = 32'h100; wdata = 32'd0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; mem_read = 3'b000;
    repeat (3) @(negedge clk);
    checks++;
    if (mb_re !== 1'b1 || mb_addr !== 32'h102) begin
      errors++;
      $display("FAIL rstmid_beat2: got re %b addr %h want 1 102", mb_re, mb_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mb_re !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: got re %b ready %b valid %b want 0 1 0", mb_re, req_ready, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mb_re !== 1'b0 || mb_we !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_random;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a, wd;
    int          sel, bad;
    for (int it = 0; it < 80; it++) begin
      sel = $urandom_range(0, 9);
      rd = 3'd0; wr = 2'd0;
      if (sel <= 3) rd = 3'($urandom_range(1, 5));
      else if (sel <= 6) wr = 2'($urandom_range(1, 3));
      else if (sel == 8) begin
        rd = 3'($urandom_range(1, 5));
        wr = 2'($urandom_range(1, 3));
      end else if (sel == 9) rd = 3'($urandom_range(6, 7));
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) : 32'($urandom_range(256, 319));
      if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
      wd = $urandom;
      model(rd, wr, a, wd);
      run_req(rd, wr, a, wd, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_lat !== exp_lat) begin
        errors++;
        $display("FAIL rnd%0d_cycle: rd %0d wr %0d addr %h got %0d want %0d", it, rd, wr, a, obs_lat, exp_lat);
      end
      checks++;
      if (obs_err !== exp_err) begin
        errors++;
        $display("FAIL rnd%0d_err: rd %0d wr %0d addr %h got %b want %b", it, rd, wr, a, obs_err, exp_err);
      end
      checks++;
      if (obs_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rnd%0d_data: rd %0d addr %h got %h want %h", it, rd, a, obs_rdata, exp_rdata);
      end
      bad = beat_mismatches(a, wd);
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rnd%0d_beats: rd %0d wr %0d addr %h got %0d bad cycles want 0", it, rd, wr, a, bad);
      end
      checks++;
      if (obs_rdy_after !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_ready_after: got %b want 1", it, obs_rdy_after);
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; mem_read = 3'b000; mem_write = 2'b00; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < 4096; i++) refm[i] = init_byte(12'(i));
    test_reset();
    test_store_word();
    test_loads();
    test_errors();
    test_sb_hold();
    test_noop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential load/store unit that executes the data-memory side of the control word: it consumes the 3-bit `mem_read` and 2-bit `mem_write` access codes produced by instruction decode and performs the access over a byte-wide data memory port. Words and halfwords take one beat per byte, little-endian. Load data is sign- or zero-extended, and misaligned or illegal requests are reported instead of executed. It sits between the core's execute stage and the byte-wide data RAM.

## Interface
- `ADDR_W`, 32, byte-address width of the request and memory ports.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: unit idle and accepting.
- `mem_read` in 3: 000 none, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU; 110/111 reserved.
- `mem_write` in 2: 00 none, 01 SW, 10 SH, 11 SB.
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data, LSB-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores, errors and no-ops.
- `rsp_err` out 1: request rejected, qualified by `rsp_valid`.
- `mb_addr` out ADDR_W: byte-memory address.
- `mb_re` out 1: byte read strobe.
- `mb_we` out 1: byte write strobe.
- `mb_wdata` out 8: byte write data.
- `mb_rdata` in 8: read byte, valid the cycle after its `mb_re` cycle.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - ISSUE: one memory beat per cycle.
  - DRAIN: loads only; captures the final byte.
  - RESP: `rsp_valid`=1.
- Accept on `req_valid && req_ready`. The unit latches `mem_read`, `mem_write`, `addr` and `wdata`; later input changes are ignored.
- Beat count N: word 4, halfword 2, byte 1. Beat i uses `mb_addr` = latched `addr` + i, i = 0..N-1.
- Stores: beat i drives `mb_we`=1 and `mb_wdata` = `wdata`[8i+7:8i].
- Loads:
  - Beat i drives `mb_re`=1. The byte on `mb_rdata` the following cycle is stored to assembly byte i.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW is used unextended.
- Error, checked at accept; no memory beats, IDLE -> RESP with `rsp_err`=1 and `rsp_rdata`=0. Any of:
  - Halfword access with `addr`[0]=1.
  - Word access with `addr`[1:0]≠00.
  - Both codes nonzero.
  - Reserved `mem_read` code.
- No-op (both codes zero): accepted, IDLE -> RESP with `rsp_err`=0 and `rsp_rdata`=0, no beats.
- Transitions:
  - IDLE -> ISSUE on legal access.
  - ISSUE -> ISSUE until beat N-1 is issued.
  - ISSUE -> DRAIN on a load; ISSUE -> RESP on a store.
  - DRAIN -> RESP.
  - RESP -> IDLE always.
- `mb_re` and `mb_we` are never high together. Both are 0 outside ISSUE, and `mb_addr`/`mb_wdata` hold their last values there.
- Address arithmetic is mod 2^ADDR_W; aligned accesses never cross a wrap.

## Timing
- Reset values:
  - `req_ready`=1 (IDLE).
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `mb_re`=0, `mb_we`=0, `mb_addr`=0, `mb_wdata`=0.
- Reset mid-operation aborts immediately. No further strobes, and the pending response is dropped.
- All outputs are registered.
- Accept at edge E0:
  - Beats occupy cycles 1..N after E0.
  - Store: `rsp_valid` in cycle N+1.
  - Load: DRAIN in cycle N+1, `rsp_valid` in cycle N+2.
  - Error/no-op: `rsp_valid` in cycle 1.
- `req_ready` rises again in the cycle after RESP. Peak throughput for LW is one request per 7 cycles (1 accept + 4 beats + DRAIN + RESP).
- `rsp_valid` is a single-cycle pulse with no backpressure. `rsp_rdata`/`rsp_err` hold until the next RESP.
- `req_valid` while busy is ignored, not queued.

## Test plan
- Reset asserted mid-LW, at beat 2 → same cycle: `mb_re`=0, `req_ready`=1, no `rsp_valid` afterward.
- SW `addr`=0x100, `wdata`=0xDEADBEEF → writes 0xEF@0x100, 0xBE@0x101, 0xAD@0x102, 0xDE@0x103 on consecutive cycles; `rsp_valid` cycle 5, `rsp_err`=0.
- Memory bytes 0x100..0x103 = 0x80,0xFF,0x12,0x34; responses:
  - LW 0x100 → 0x3412FF80 in cycle 6.
  - LH 0x100 → 0xFFFFFF80.
  - LHU 0x100 → 0x0000FF80.
  - LB 0x100 → 0xFFFFFF80.
  - LBU 0x101 → 0x000000FF.
- Each of the following gives `rsp_err`=1, `rsp_rdata`=0 in cycle 1, with zero `mb_re`/`mb_we` pulses:
  - LW @0x102.
  - SH @0x101.
  - `mem_read`=110.
  - `mem_read`=001 with `mem_write`=01.
- SB @0x103, `wdata`=0xAABBCC5A → single write 0x5A@0x103; `req_valid` held high during the busy cycles is not accepted until `req_ready` returns.
- No-op request (both codes 0) → `rsp_valid` cycle 1, `rsp_err`=0, no memory strobes.
